// File: rtl/dpram_bist_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : dpram_bist_ctrl                                            |
// | Description : Write/read-back self-test sequencer for ip_dpram. A start  |
// |               pulse writes DEPTH words of a descending pattern, waits GAP |
// |               idle cycles, reads the words back and compares q against   |
// |               the expected pattern. The result is reported on err and    |
// |               err_cnt together with a one-cycle done pulse.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clock      in   1         system clock, rising edge                    |
// |   reset      in   1         synchronous active-high reset                |
// |   start      in   1         one-cycle run request (accepted in IDLE)     |
// |   wren       out  1         ip_dpram write enable                        |
// |   wraddress  out  ADDR_W    ip_dpram write address                       |
// |   data       out  DATA_W    ip_dpram write data                          |
// |   rdaddress  out  ADDR_W    ip_dpram read address                        |
// |   q          in   DATA_W    ip_dpram read data (RD_LAT clocks latency)   |
// |   busy       out  1         run in progress                              |
// |   done       out  1         one-cycle end-of-run pulse                   |
// |   err        out  1         sticky mismatch flag for current/last run    |
// |   err_cnt    out  ADDR_W+1  saturating mismatch count                    |
// | Optional build macro DPRAM_BIST_ERR_CAPTURE_EN adds:                     |
// |   err_addr   out  ADDR_W    address of first mismatch of the run         |
// |   err_exp    out  DATA_W    expected value of first mismatch             |
// |   err_got    out  DATA_W    q value of first mismatch                    |
// +--------------------------------------------------------------------------+
module dpram_bist_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 16,
    parameter int PAT_BASE = 255,
    parameter int GAP      = 20,
    parameter int RD_LAT   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   err_cnt
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_got
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Index counter is one bit wider than the address so DEPTH = 2^ADDR_W
    // reaches its last index without wrapping.
    localparam int c_IDX_W    = ADDR_W + 1;
    localparam int c_WAIT_MAX = (GAP > RD_LAT) ? GAP : RD_LAT;
    localparam int c_WAIT_W   = (c_WAIT_MAX > 1) ? $clog2(c_WAIT_MAX) : 1;

    localparam logic [c_IDX_W-1:0]  c_LAST       = c_IDX_W'(DEPTH - 1);
    localparam logic [c_WAIT_W-1:0] c_GAP_LAST   = c_WAIT_W'(GAP - 1);
    localparam logic [c_WAIT_W-1:0] c_DRAIN_LAST = c_WAIT_W'(RD_LAT - 1);
    localparam logic [DATA_W-1:0]   c_PAT        = DATA_W'(PAT_BASE);
    localparam logic [ADDR_W:0]     c_CNT_MAX    = '1;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_WRITE = 3'd1;
    localparam logic [2:0] c_S_GAP   = 3'd2;
    localparam logic [2:0] c_S_READ  = 3'd3;
    localparam logic [2:0] c_S_DRAIN = 3'd4;
    localparam logic [2:0] c_S_FIN   = 3'd5;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_WAIT_W-1:0] r_wait;

    logic                w_accept;
    logic [DATA_W-1:0]   w_pat;
    logic [ADDR_W-1:0]   w_idx_a;

    logic                w_wren_nxt;
    logic [ADDR_W-1:0]   w_wraddr_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_rd_vld_nxt;
    logic [ADDR_W-1:0]   w_rdaddr_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    logic                r_wren;
    logic [ADDR_W-1:0]   r_wraddress;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_rdaddress;
    logic                r_rd_vld;
    logic [DATA_W-1:0]   r_rd_exp;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W:0]     r_err_cnt;

    logic                w_cmp_vld;
    logic [DATA_W-1:0]   w_cmp_exp;
    logic                w_mis;
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
    logic [ADDR_W-1:0]   w_cmp_addr;
    logic [ADDR_W-1:0]   r_err_addr;
    logic [DATA_W-1:0]   r_err_exp;
    logic [DATA_W-1:0]   r_err_got;
`endif

    assign w_accept = (r_state == c_S_IDLE) && start;
    assign w_idx_a  = r_idx[ADDR_W-1:0];
    // Modulo-2^DATA_W descending pattern.
    assign w_pat    = c_PAT - DATA_W'(r_idx);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin : p_state_reg
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) w_state_nxt = c_S_WRITE;
            end
            c_S_WRITE: begin
                if (r_idx == c_LAST) w_state_nxt = (GAP == 0) ? c_S_READ : c_S_GAP;
            end
            c_S_GAP: begin
                if (r_wait == c_GAP_LAST) w_state_nxt = c_S_READ;
            end
            c_S_READ: begin
                if (r_idx == c_LAST) w_state_nxt = (RD_LAT == 0) ? c_S_FIN : c_S_DRAIN;
            end
            c_S_DRAIN: begin
                if (r_wait == c_DRAIN_LAST) w_state_nxt = c_S_FIN;
            end
            c_S_FIN: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (values loaded into the output registers)
    // ------------------------------------------------------------------
    always_comb begin : p_out_comb
        w_wren_nxt   = 1'b0;
        w_wraddr_nxt = '0;
        w_data_nxt   = '0;
        w_rd_vld_nxt = 1'b0;
        w_rdaddr_nxt = r_rdaddress;   // read address holds outside READ
        w_done_nxt   = (r_state == c_S_FIN);
        w_busy_nxt   = r_busy;
        case (r_state)
            c_S_WRITE: begin
                w_wren_nxt   = 1'b1;
                w_wraddr_nxt = w_idx_a;
                w_data_nxt   = w_pat;
            end
            c_S_READ: begin
                w_rd_vld_nxt = 1'b1;
                w_rdaddr_nxt = w_idx_a;
            end
            default: ;
        endcase
        if (w_accept) begin
            w_busy_nxt = 1'b1;
        end else if (r_state == c_S_FIN) begin
            w_busy_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Index and wait counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin : p_counters
        if (reset) begin
            r_idx  <= '0;
            r_wait <= '0;
        end else begin
            if ((r_state == c_S_WRITE) || (r_state == c_S_READ)) begin
                r_idx <= (r_idx == c_LAST) ? '0 : r_idx + c_IDX_W'(1);
            end else begin
                r_idx <= '0;
            end
            // Wait counter runs while staying in GAP or DRAIN.
            if (((r_state == c_S_GAP) || (r_state == c_S_DRAIN)) && (w_state_nxt == r_state)) begin
                r_wait <= r_wait + c_WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin : p_out_reg
        if (reset) begin
            r_wren      <= 1'b0;
            r_wraddress <= '0;
            r_data      <= '0;
            r_rdaddress <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_exp    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wren      <= w_wren_nxt;
            r_wraddress <= w_wraddr_nxt;
            r_data      <= w_data_nxt;
            r_rdaddress <= w_rdaddr_nxt;
            r_rd_vld    <= w_rd_vld_nxt;
            r_rd_exp    <= w_pat;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Expected-value pipeline: r_rd_vld/r_rd_exp are aligned with
    // rdaddress, so RD_LAT further stages line them up with q.
    // ------------------------------------------------------------------
    generate
        if (RD_LAT > 0) begin : g_pipe
            logic [RD_LAT-1:0] r_pv;
            logic [DATA_W-1:0] r_pe [RD_LAT];
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
            logic [ADDR_W-1:0] r_pa [RD_LAT];
`endif
            always_ff @(posedge clock) begin : p_pipe
                if (reset) begin
                    r_pv <= '0;
                    for (int k = 0; k < RD_LAT; k++) begin
                        r_pe[k] <= '0;
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
                        r_pa[k] <= '0;
`endif
                    end
                end else begin
                    r_pv[0] <= r_rd_vld;
                    r_pe[0] <= r_rd_exp;
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
                    r_pa[0] <= r_rdaddress;
`endif
                    for (int k = 1; k < RD_LAT; k++) begin
                        r_pv[k] <= r_pv[k-1];
                        r_pe[k] <= r_pe[k-1];
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
                        r_pa[k] <= r_pa[k-1];
`endif
                    end
                end
            end
            assign w_cmp_vld  = r_pv[RD_LAT-1];
            assign w_cmp_exp  = r_pe[RD_LAT-1];
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
            assign w_cmp_addr = r_pa[RD_LAT-1];
`endif
        end else begin : g_nopipe
            assign w_cmp_vld  = r_rd_vld;
            assign w_cmp_exp  = r_rd_exp;
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
            assign w_cmp_addr = r_rdaddress;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Compare and error accounting (cleared by reset and accepted start)
    // ------------------------------------------------------------------
    assign w_mis = w_cmp_vld && (q != w_cmp_exp);

    always_ff @(posedge clock) begin : p_err
        if (reset || w_accept) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_mis) begin
            r_err <= 1'b1;
            if (r_err_cnt != c_CNT_MAX) r_err_cnt <= r_err_cnt + (ADDR_W+1)'(1);
        end
    end

`ifdef DPRAM_BIST_ERR_CAPTURE_EN
    // Only the first mismatch of a run is captured (r_err still low).
    always_ff @(posedge clock) begin : p_err_capture
        if (reset || w_accept) begin
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else if (w_mis && !r_err) begin
            r_err_addr <= w_cmp_addr;
            r_err_exp  <= w_cmp_exp;
            r_err_got  <= q;
        end
    end

    assign err_addr = r_err_addr;
    assign err_exp  = r_err_exp;
    assign err_got  = r_err_got;
`endif

    assign wren      = r_wren;
    assign wraddress = r_wraddress;
    assign data      = r_data;
    assign rdaddress = r_rdaddress;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dpram_bist_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_dpram_bist_ctrl                                         |
// | Description : Directed self-checking bench for dpram_bist_ctrl with two  |
// |               instances (default build and DEPTH=256/GAP=0/PAT_BASE=0),  |
// |               each driving a behavioural two-clock-latency RAM model.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dpram_bist_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, start_a, start_b, fault_a;

    logic       wren_a, busy_a, done_a, err_a;
    logic [7:0] wraddress_a, data_a, rdaddress_a, q_a;
    logic [8:0] err_cnt_a;
    logic       wren_b, busy_b, done_b, err_b;
    logic [7:0] wraddress_b, data_b, rdaddress_b, q_b;
    logic [8:0] err_cnt_b;
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
    logic [7:0] err_addr_a, err_exp_a, err_got_a;
    logic [7:0] err_addr_b, err_exp_b, err_got_b;
`endif

    dpram_bist_ctrl u_dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .wren(wren_a), .wraddress(wraddress_a), .data(data_a),
        .rdaddress(rdaddress_a), .q(q_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_cnt(err_cnt_a)
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
        , .err_addr(err_addr_a), .err_exp(err_exp_a), .err_got(err_got_a)
`endif
    );

    dpram_bist_ctrl #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(256), .PAT_BASE(0), .GAP(0), .RD_LAT(2)
    ) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .wren(wren_b), .wraddress(wraddress_b), .data(data_b),
        .rdaddress(rdaddress_b), .q(q_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_cnt(err_cnt_b)
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
        , .err_addr(err_addr_b), .err_exp(err_exp_b), .err_got(err_got_b)
`endif
    );

    // RAM models: address register + output register (2 clocks latency).
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] ra_a, ra_b;

    always @(posedge clock) begin
        if (wren_a) mem_a[wraddress_a] <= data_a;
        ra_a <= rdaddress_a;
        q_a  <= (fault_a && ra_a == 8'd5) ? 8'h00 : mem_a[ra_a];
        if (wren_b) mem_b[wraddress_b] <= data_b;
        ra_b <= rdaddress_b;
        q_b  <= mem_b[ra_b];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One run on instance A. x1..x3 are cycles (relative to the start
    // cycle = 0) at which an extra start pulse is applied.
    task automatic run_a(input int x1, input int x2, input int x3,
                         output int dcyc, output int nwr, output int wbad,
                         output int bbad, output int clr_bad);
        dcyc = -1; nwr = 0; wbad = 0; bbad = 0; clr_bad = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc == 1) begin
                if (err_a !== 1'b0 || err_cnt_a !== 9'd0) clr_bad++;
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
                if (err_addr_a !== 8'd0 || err_exp_a !== 8'd0 || err_got_a !== 8'd0) clr_bad++;
`endif
            end
            if (done_a) begin
                dcyc = cyc;
                break;
            end
            if (!busy_a) bbad++;
            if (wren_a) begin
                if (wraddress_a !== 8'(nwr) || data_a !== 8'(255 - nwr)) wbad++;
                nwr++;
            end
            start_a = (cyc == x1) || (cyc == x2) || (cyc == x3);
            tick();
        end
        start_a = 1'b0;
    endtask

    initial begin
        int dc, nw, wb, bb, cb, ndone;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; fault_a = 1'b0;
        repeat (5) tick();

        // Reset state
        chk("rst_wren", wren_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_err_cnt", err_cnt_a, 0);
        chk("rst_wraddress", wraddress_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_rdaddress", rdaddress_a, 0);
        reset = 1'b0;
        tick();

        // Pass run: done at cycle 1+16+20+16+2+1 = 56
        run_a(0, 0, 0, dc, nw, wb, bb, cb);
        chk("pass_done_cycle", dc, 56);
        chk("pass_writes", nw, 16);
        chk("pass_write_bad", wb, 0);
        chk("pass_busy_bad", bb, 0);
        chk("pass_busy_at_done", busy_a, 0);
        chk("pass_err", err_a, 0);
        chk("pass_err_cnt", err_cnt_a, 0);
        chk("pass_rdaddr_hold", rdaddress_a, 15);
        chk("pass_wraddr_fin", wraddress_a, 0);
        chk("pass_data_fin", data_a, 0);
        chk("pass_mem0", mem_a[0], 255);
        chk("pass_mem15", mem_a[15], 240);
        tick();
        chk("pass_idle_busy", busy_a, 0);
        chk("pass_done_width", done_a, 0);

        // Faulted run with ignored starts in WRITE, READ and FIN
        fault_a = 1'b1;
        run_a(8, 45, 55, dc, nw, wb, bb, cb);
        chk("fault_done_cycle", dc, 56);
        chk("fault_writes", nw, 16);
        chk("fault_write_bad", wb, 0);
        chk("fault_busy_bad", bb, 0);
        chk("fault_busy_at_done", busy_a, 0);
        chk("fault_err", err_a, 1);
        chk("fault_err_cnt", err_cnt_a, 1);
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
        chk("fault_err_addr", err_addr_a, 5);
        chk("fault_err_exp", err_exp_a, 250);
        chk("fault_err_got", err_got_a, 0);
`endif

        // Back-to-back: start in the cycle right after FIN (the done cycle)
        fault_a = 1'b0;
        run_a(0, 0, 0, dc, nw, wb, bb, cb);
        chk("b2b_cleared", cb, 0);
        chk("b2b_done_cycle", dc, 56);
        chk("b2b_writes", nw, 16);
        chk("b2b_err", err_a, 0);
        chk("b2b_err_cnt", err_cnt_a, 0);

        // Reset mid-run at write index 7
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wren_a && wraddress_a == 8'd7) break;
            tick();
        end
        chk("midrst_reach_idx7", {wren_a, wraddress_a}, {1'b1, 8'd7});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_wren", wren_a, 0);
        chk("midrst_busy", busy_a, 0);
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            if (done_a) ndone++;
            tick();
        end
        chk("midrst_no_done", ndone, 0);
        run_a(0, 0, 0, dc, nw, wb, bb, cb);
        chk("after_rst_done_cycle", dc, 56);
        chk("after_rst_write_bad", wb, 0);
        chk("after_rst_err", err_a, 0);

        // Boundary: DEPTH=256, GAP=0, PAT_BASE=0; done at 1+256+0+256+2+1 = 516
        nw = 0; wb = 0; dc = -1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            if (done_b) begin
                dc = cyc;
                break;
            end
            if (wren_b) begin
                if (wraddress_b !== 8'(nw) || data_b !== 8'(0 - nw)) wb++;
                nw++;
            end
            tick();
        end
        chk("bnd_done_cycle", dc, 516);
        chk("bnd_writes", nw, 256);
        chk("bnd_write_bad", wb, 0);
        chk("bnd_err", err_b, 0);
        chk("bnd_err_cnt", err_cnt_b, 0);
        chk("bnd_rdaddr_hold", rdaddress_b, 255);
        chk("bnd_mem0", mem_b[0], 0);
        chk("bnd_mem1", mem_b[1], 255);
        chk("bnd_mem255", mem_b[255], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
